// File: rtl/lab7_selftest_seq.sv
// rtl/lab7_selftest_seq.sv - on-board self-test sequencer for the lab7 CPU top
// Optional: SELFTEST_STOP_ON_FAIL_EN ends the run on the first mismatch and freezes the DUT in reset.
module lab7_selftest_seq #(
  parameter int DATA_W     = 16,
  parameter int SW_W       = 10,
  parameter int NUM_CHECKS = 4,
  parameter int RST_CYCLES = 2,
  parameter int RUN_CYCLES = 100,
  localparam int ERR_W     = $clog2(NUM_CHECKS + 1),
  localparam int IDX_W     = ($clog2(NUM_CHECKS) > 0) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [SW_W-1:0]              sw_cfg,
  input  logic [NUM_CHECKS*DATA_W-1:0] exp_data,
  input  logic [DATA_W-1:0]            obs_data,
  output logic                         dut_reset_n,
  output logic [SW_W-1:0]              dut_sw,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [ERR_W-1:0]             err_count,
  output logic [IDX_W-1:0]             fail_idx
);

  localparam int MAX_CNT = (RST_CYCLES > RUN_CYCLES) ? RST_CYCLES : RUN_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CNT) > 0) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHECKS - 1);

  typedef enum logic [2:0] {IDLE, HOLD_RST, RUN, CHECK, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             mismatch;
  logic             stop_now;

  assign mismatch = (obs_data != exp_data[idx*DATA_W +: DATA_W]);

`ifdef SELFTEST_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      dut_reset_n <= 1'b0;
      dut_sw      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      fail_idx    <= '0;
      idx         <= '0;
      cnt         <= '0;
    end else if (abort) begin
      // Abort beats start; error history is kept for inspection.
      state       <= IDLE;
      dut_reset_n <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      idx         <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= HOLD_RST;
            dut_sw      <= sw_cfg;
            dut_reset_n <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            fail_idx    <= '0;
            idx         <= '0;
            cnt         <= '0;
          end
        end
        HOLD_RST: begin
          if (cnt == RST_LAST) begin
            state       <= RUN;
            dut_reset_n <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (cnt == RUN_LAST) begin
            state <= CHECK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          if (mismatch) begin
            err_count <= err_count + ERR_W'(1);
            if (err_count == '0) fail_idx <= idx;
          end
          if (idx == IDX_LAST || stop_now) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !mismatch && (err_count == '0);
            if (stop_now) dut_reset_n <= 1'b0;
          end else begin
            state <= RUN;
            idx   <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lab7_selftest_seq.sv
// tb/tb_lab7_selftest_seq.sv - directed self-checking bench for lab7_selftest_seq
module tb_lab7_selftest_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [9:0]  sw_cfg;
  logic [63:0] exp_data;
  logic [15:0] obs_data;
  logic        dut_reset_n;
  logic [9:0]  dut_sw;
  logic        busy;
  logic        done;
  logic        pass;
  logic [2:0]  err_count;
  logic [1:0]  fail_idx;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] slot [4] = '{16'hA5A5, 16'h1234, 16'hBEEF, 16'hDEAD};

  lab7_selftest_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .sw_cfg(sw_cfg), .exp_data(exp_data), .obs_data(obs_data),
    .dut_reset_n(dut_reset_n), .dut_sw(dut_sw), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .fail_idx(fail_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start; returns just after the start edge.
  task automatic begin_run(input logic [9:0] sw);
    sw_cfg = sw;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Presents obs for checks lo..hi, ending just after each check edge.
  task automatic run_checks(input int lo, input int hi, input logic [3:0] bad);
    for (int k = lo; k <= hi; k++) begin
      obs_data = slot[k] ^ (bad[k] ? 16'h0100 : 16'h0000);
      repeat (101) tick();
    end
  endtask

  task automatic test_reset();
    vectors++; if (dut_reset_n !== 1'b0) begin miscompares++; $display("FAIL reset_dut_reset_n got=%b exp=0", dut_reset_n); end
    vectors++; if ({busy, done, pass} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got=%b exp=000", {busy, done, pass}); end
    vectors++; if (err_count !== 3'd0 || dut_sw !== 10'd0) begin miscompares++; $display("FAIL reset_err_sw got=%0d/%h exp=0/000", err_count, dut_sw); end
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    vectors++; if ({busy, done, dut_reset_n} !== 3'b000) begin miscompares++; $display("FAIL idle_hold got=%b exp=000", {busy, done, dut_reset_n}); end
  endtask

  task automatic test_pass_run();
    begin_run(10'h001);
    vectors++; if (dut_reset_n !== 1'b0 || busy !== 1'b1 || dut_sw !== 10'h001) begin miscompares++; $display("FAIL pass_start got=%b/%b/%h exp=0/1/001", dut_reset_n, busy, dut_sw); end
    tick();
    vectors++; if (dut_reset_n !== 1'b0) begin miscompares++; $display("FAIL pass_rst_cyc2 got=%b exp=0", dut_reset_n); end
    tick();
    vectors++; if (dut_reset_n !== 1'b1) begin miscompares++; $display("FAIL pass_release got=%b exp=1", dut_reset_n); end
    run_checks(0, 2, 4'b0000);
    obs_data = slot[3];
    repeat (100) tick();
    vectors++; if (done !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL pass_early_done got=%b/%b exp=0/1", done, busy); end
    tick();
    vectors++; if ({done, pass, busy} !== 3'b110 || err_count !== 3'd0) begin miscompares++; $display("FAIL pass_done got=%b err=%0d exp=110 err=0", {done, pass, busy}, err_count); end
    vectors++; if (dut_reset_n !== 1'b1) begin miscompares++; $display("FAIL pass_done_rst got=%b exp=1", dut_reset_n); end
  endtask

  task automatic test_fail_checks();
    begin_run(10'h2A5);
    tick(); tick();
`ifdef SELFTEST_STOP_ON_FAIL_EN
    run_checks(0, 1, 4'b1010);
    vectors++; if ({done, pass} !== 2'b10 || err_count !== 3'd1 || fail_idx !== 2'd1) begin miscompares++; $display("FAIL stop_done got=%b err=%0d idx=%0d exp=10 err=1 idx=1", {done, pass}, err_count, fail_idx); end
    vectors++; if (dut_reset_n !== 1'b0) begin miscompares++; $display("FAIL stop_frozen got=%b exp=0", dut_reset_n); end
`else
    run_checks(0, 3, 4'b1010);
    vectors++; if ({done, pass} !== 2'b10 || err_count !== 3'd2 || fail_idx !== 2'd1) begin miscompares++; $display("FAIL fail_done got=%b err=%0d idx=%0d exp=10 err=2 idx=1", {done, pass}, err_count, fail_idx); end
    vectors++; if (dut_reset_n !== 1'b1 || dut_sw !== 10'h2A5) begin miscompares++; $display("FAIL fail_dut got=%b/%h exp=1/2a5", dut_reset_n, dut_sw); end
`endif
  endtask

  task automatic test_abort();
    begin_run(10'h0F0);
    tick(); tick();
    repeat (50) tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    vectors++; if ({busy, done, pass, dut_reset_n} !== 4'b0000) begin miscompares++; $display("FAIL abort_idle got=%b exp=0000", {busy, done, pass, dut_reset_n}); end
    repeat (5) tick();
    vectors++; if ({busy, dut_reset_n} !== 2'b00 || err_count !== 3'd0) begin miscompares++; $display("FAIL abort_no_start got=%b err=%0d exp=00 err=0", {busy, dut_reset_n}, err_count); end
  endtask

  task automatic test_start_while_busy();
    begin_run(10'h155);
    tick(); tick();
    obs_data = slot[0];
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (busy !== 1'b1 || dut_reset_n !== 1'b1) begin miscompares++; $display("FAIL busy_restart got=%b/%b exp=1/1", busy, dut_reset_n); end
    repeat (90) tick();
    run_checks(1, 2, 4'b0000);
    obs_data = slot[3];
    repeat (100) tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL busy_early got=%b exp=0", done); end
    tick();
    vectors++; if ({done, pass} !== 2'b11 || dut_sw !== 10'h155) begin miscompares++; $display("FAIL busy_done got=%b/%h exp=11/155", {done, pass}, dut_sw); end
  endtask

  task automatic test_reset_in_check();
    begin_run(10'h3FF);
    tick(); tick();
    obs_data = 16'h0000;
    repeat (100) tick();
    vectors++; if (busy !== 1'b1 || dut_reset_n !== 1'b1) begin miscompares++; $display("FAIL pre_check got=%b/%b exp=1/1", busy, dut_reset_n); end
    reset_n = 1'b0;
    #1;
    vectors++; if ({busy, done, pass, dut_reset_n} !== 4'b0000 || dut_sw !== 10'd0 || err_count !== 3'd0) begin miscompares++; $display("FAIL async_reset got=%b sw=%h err=%0d exp=0000 sw=000 err=0", {busy, done, pass, dut_reset_n}, dut_sw, err_count); end
    #2;
    reset_n = 1'b1;
    tick();
    begin_run(10'h001);
    tick(); tick();
    run_checks(0, 3, 4'b0000);
    vectors++; if ({done, pass} !== 2'b11 || err_count !== 3'd0) begin miscompares++; $display("FAIL rerun_pass got=%b err=%0d exp=11 err=0", {done, pass}, err_count); end
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    sw_cfg   = 10'd0;
    obs_data = 16'd0;
    exp_data = {slot[3], slot[2], slot[1], slot[0]};
    #2;
    test_reset();
    test_pass_run();
    test_fail_checks();
    test_abort();
    test_start_while_busy();
    test_reset_in_check();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
